// File: rtl/dds_pkg.sv
// Shared DDS front-panel definitions: one-hot waveform codes, debounce FSM
// encoding and the priority pick used when several keys flag together.
package dds_pkg;

  localparam logic [3:0] WAVE_SINE   = 4'b0001;
  localparam logic [3:0] WAVE_SQUARE = 4'b0010;
  localparam logic [3:0] WAVE_TRI    = 4'b0100;
  localparam logic [3:0] WAVE_SAW    = 4'b1000;

  typedef enum logic [1:0] {
    S_UP    = 2'd0,
    S_DB_DN = 2'd1,
    S_DOWN  = 2'd2,
    S_DB_UP = 2'd3
  } db_state_e;

  // Lowest-indexed set flag wins; an all-zero input falls back to sine.
  function automatic logic [3:0] prio_onehot(input logic [3:0] flags);
    logic [3:0] code;
    code = WAVE_SINE;
    if (flags[0])      code = WAVE_SINE;
    else if (flags[1]) code = WAVE_SQUARE;
    else if (flags[2]) code = WAVE_TRI;
    else if (flags[3]) code = WAVE_SAW;
    return code;
  endfunction

endpackage

// File: rtl/key_filter.sv
// One push-button: two-flop synchroniser, press/release debounce FSM and a
// registered one-cycle pulse on each accepted press.
module key_filter
  import dds_pkg::*;
#(
  parameter int CNT_MAX = 999_999,
  parameter int CNT_W   = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  logic             sync1_q;
  logic             key_s_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      key_s_q <= 1'b1;
      state_q <= S_UP;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      key_s_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_UP: begin
        if (!key_s_q) begin
          state_d = S_DB_DN;
          cnt_d   = '0;
        end
      end
      S_DB_DN: begin
        if (key_s_q)                state_d = S_UP;
        else if (cnt_q == CNT_LAST) state_d = S_DOWN;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DOWN: begin
        if (key_s_q) begin
          state_d = S_DB_UP;
          cnt_d   = '0;
        end
      end
      S_DB_UP: begin
        if (!key_s_q)               state_d = S_DOWN;
        else if (cnt_q == CNT_LAST) state_d = S_UP;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_UP;
    endcase
  end

  // The pulse fires on the same edge that moves the FSM into S_DOWN.
  always_comb begin
    press_d = (state_q == S_DB_DN) && !key_s_q && (cnt_q == CNT_LAST);
  end

  assign press_o = press_q;

endmodule

// File: rtl/wave_sel_ctrl.sv
// Front-panel waveform selector: four debounced keys feed a flag register,
// and the lowest flagged key's one-hot code is latched into wave_sel.
module wave_sel_ctrl
  import dds_pkg::*;
#(
  parameter int CNT_MAX = 999_999,
  parameter int CNT_W   = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key_n,
  output logic [3:0] key_flag,
  output logic [3:0] wave_sel
);

  logic [3:0] press;
  logic [3:0] key_flag_q;
  logic [3:0] wave_sel_q, wave_sel_d;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_filter #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W)
    ) u_key_filter (
      .clk_i   (sys_clk),
      .rst_i   (sys_rst),
      .key_n_i (key_n[g]),
      .press_o (press[g])
    );
  end

  always_comb begin
    wave_sel_d = wave_sel_q;
    if (|key_flag_q) wave_sel_d = prio_onehot(key_flag_q);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_flag_q <= 4'b0000;
      wave_sel_q <= WAVE_SINE;
    end else begin
      key_flag_q <= press;
      wave_sel_q <= wave_sel_d;
    end
  end

  assign key_flag = key_flag_q;
  assign wave_sel = wave_sel_q;

endmodule
